if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage RV32I core: owns the PC, issues word fetches to instruction memory over a req/ready/rvalid handshake, and drives the IF/ID pipeline register that feeds the decoder and `control`. It applies the two redirects produced downstream: the taken-branch flush from EX (`bxx_flush`) and the JALR redirect decided in ID (`if_jalr_en`). It also absorbs ID stalls with a one-entry skid buffer.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP_INSTR`, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID
- `clk`  in  1  core clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  32  fetch address (word aligned, = pc)
- `imem_ready`  in  1  request accepted this cycle when `imem_req` is also 1
- `imem_rvalid`  in  1  read data valid (at most one outstanding, in order)
- `imem_rdata`  in  32  instruction word
- `stall_id`  in  1  hold IF/ID (load-use hazard)
- `bxx_flush`  in  1  EX redirect (taken branch/JAL)
- `branch_target`  in  32  EX redirect target
- `if_jalr_en`  in  1  ID JALR redirect
- `jalr_target`  in  32  rs1+imm from ID
- `id_valid`  out  1  IF/ID holds a real instruction
- `id_instr`  out  32  IF/ID instruction
- `id_pc`  out  32  IF/ID instruction address
- `id_pc4`  out  32  id_pc + 4

## Operation
- Registers: `pc` (next address to issue), `fetch_pc` (address of the outstanding fetch), `drop` (discard the next response), skid buffer (`sk_valid`, `sk_instr`, `sk_pc`), FSM state.
- FSM states:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: `imem_req`=1.
  - WAIT: one fetch outstanding.
  - HOLD: skid buffer full.
- redirect = `bxx_flush` | (`if_jalr_en` & !`stall_id`). `bxx_flush` has priority; target = `branch_target` if `bxx_flush`, else `jalr_target`. Bits [1:0] of the target are forced to 00.
- `imem_req` = !redirect & ((REQ) | (WAIT & `imem_rvalid` & !`drop` & !`stall_id`)). This allows back-to-back fetches.
- Accept (`imem_req` & `imem_ready`): `fetch_pc`<=`pc`, `pc`<=`pc`+4 (mod 2^32), state WAIT.
- Good response (WAIT & `imem_rvalid` & !`drop`), no redirect:
  - `stall_id`=0: IF/ID <= {1, rdata, `fetch_pc`}. State WAIT if a new request was accepted, else REQ.
  - `stall_id`=1: skid <= {rdata, `fetch_pc`}, state HOLD; IF/ID unchanged.
- HOLD & !`stall_id`: IF/ID <= skid, `sk_valid`<=0, state REQ.
- `stall_id`=1 without a capture: IF/ID holds all fields.
- `stall_id`=0 with no capture and no skid transfer: `id_valid`<=0, `id_instr`<=`NOP_INSTR`.
- Redirect (any state):
  - `pc`<=target; `id_valid`<=0; `id_instr`<=`NOP_INSTR`; `sk_valid`<=0.
  - Any response arriving in the redirect cycle is discarded.
  - In WAIT without `imem_rvalid` in that cycle: `drop`<=1, stay WAIT. Otherwise state REQ.
  - Exception: when `stall_id`=1 and `bxx_flush`=1, IF/ID is still bubbled (flush beats stall).
- Dropped response (WAIT & `imem_rvalid` & `drop`): `drop`<=0, state REQ, no IF/ID write.
- `imem_rdata` is ignored when `imem_rvalid`=0. Responses outside WAIT are a protocol error and are ignored.

## Timing
- Reset (async assert) values:
  - `pc`=`RESET_PC`, `fetch_pc`=0, state IDLE, `drop`=0, `sk_valid`=0.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `id_valid`=0, `id_instr`=`NOP_INSTR`, `id_pc`=0, `id_pc4`=4.
- Deassertion of `rst_n` takes effect at the next clock edge.
- First request: 2nd edge after reset release (IDLE→REQ). With zero-wait memory (`imem_ready`=1, rvalid one cycle after accept), the first instruction is valid in IF/ID 2 cycles after the first request. Throughput thereafter is 1 instruction/cycle.
- Redirect penalty:
  - Redirect in cycle N → request to target in cycle N+1.
  - Target instruction is in IF/ID at cycle N+3 (zero-wait).
  - If a stale fetch is outstanding, add its remaining latency.
- `imem_addr`/`imem_req` are combinational from registers and `imem_rvalid`/`stall_id`/redirect inputs. There is no combinational path from `imem_ready` to any output.
- `id_pc4` is registered alongside `id_pc`.

## Test plan
- Reset, `RESET_PC`=0x100, zero-wait memory returning addr as data → `imem_addr` sequence 0x100, 0x104, 0x108 on consecutive cycles. `id_pc`/`id_instr` follow 2 cycles behind, `id_valid`=1 continuously.
- `stall_id`=1 for 3 cycles while a response returns → IF/ID holds its old value, skid captures the new word, no new `imem_req`. On release, the skid word enters IF/ID with no instruction lost or duplicated.
- `bxx_flush`=1, `branch_target`=0x203 while a fetch to 0x10C is outstanding and rvalid is late → next request is to 0x200. The 0x10C response is dropped. `id_valid`=0 until the 0x200 word arrives.
- `bxx_flush` and `if_jalr_en` in the same cycle (targets 0x400 and 0x800) → fetch goes to 0x400.
- `if_jalr_en`=1 while `stall_id`=1 → ignored; `pc` unchanged. Same with `stall_id`=0 → redirect to `jalr_target`.
- `rst_n` asserted mid-WAIT with rvalid pending → all outputs immediately take their reset values. A late response after reset release is not written to IF/ID.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready/rvalid port,
// and drives the IF/ID register with a one-entry skid buffer for ID stalls.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_id,
  input  logic        bxx_flush,
  input  logic [31:0] branch_target,
  input  logic        if_jalr_en,
  input  logic [31:0] jalr_target,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_fetch_pc;
  logic        r_drop;
  logic        r_sk_valid;
  logic [31:0] r_sk_instr;
  logic [31:0] r_sk_pc;
  logic        r_id_valid;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc4;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_resp;
  logic        w_resp_good;
  logic        w_resp_drop;
  logic        w_sk_xfer;
  logic        w_req;
  logic        w_accept;

  // A JALR decided in a stalled ID is not yet final, so only the EX flush may redirect then.
  assign w_redirect  = bxx_flush | (if_jalr_en & ~stall_id);
  assign w_target    = (bxx_flush ? branch_target : jalr_target) & 32'hFFFF_FFFC;
  assign w_resp      = (r_state == S_WAIT) & imem_rvalid;
  assign w_resp_good = w_resp & ~r_drop;
  assign w_resp_drop = w_resp & r_drop;
  assign w_sk_xfer   = (r_state == S_HOLD) & r_sk_valid & ~stall_id;
  assign w_accept    = w_req & imem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (w_redirect)    w_state_nxt = S_REQ;
        else if (w_accept) w_state_nxt = S_WAIT;
        else               w_state_nxt = S_REQ;
      end
      S_WAIT: begin
        // A redirect with the stale fetch still in flight waits it out and drops it.
        if (w_redirect)         w_state_nxt = imem_rvalid ? S_REQ : S_WAIT;
        else if (w_resp_drop)   w_state_nxt = S_REQ;
        else if (w_resp_good) begin
          if (stall_id)         w_state_nxt = S_HOLD;
          else if (w_accept)    w_state_nxt = S_WAIT;
          else                  w_state_nxt = S_REQ;
        end else                w_state_nxt = S_WAIT;
      end
      S_HOLD: begin
        if (w_redirect || !stall_id) w_state_nxt = S_REQ;
        else                         w_state_nxt = S_HOLD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_req = 1'b0;
    if (w_redirect)                      w_req = 1'b0;
    else if (r_state == S_REQ)           w_req = 1'b1;
    else if (w_resp_good && !stall_id)   w_req = 1'b1;
    else                                 w_req = 1'b0;
  end

  assign imem_req  = w_req;
  assign imem_addr = r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_fetch_pc <= 32'h0000_0000;
      r_drop     <= 1'b0;
    end else begin
      if (w_redirect)    r_pc <= w_target;
      else if (w_accept) r_pc <= r_pc + 32'd4;
      if (w_accept) r_fetch_pc <= r_pc;
      if (w_resp)                                r_drop <= 1'b0;
      else if (w_redirect && r_state == S_WAIT)  r_drop <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sk_valid <= 1'b0;
      r_sk_instr <= NOP_INSTR;
      r_sk_pc    <= 32'h0000_0000;
    end else if (w_redirect) begin
      r_sk_valid <= 1'b0;
    end else if (w_resp_good && stall_id) begin
      r_sk_valid <= 1'b1;
      r_sk_instr <= imem_rdata;
      r_sk_pc    <= r_fetch_pc;
    end else if (w_sk_xfer) begin
      r_sk_valid <= 1'b0;
    end
  end

  // Flush wins over stall: a redirect always bubbles IF/ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
      r_id_pc    <= 32'h0000_0000;
      r_id_pc4   <= 32'h0000_0004;
    end else if (w_redirect) begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
    end else if (w_resp_good && !stall_id) begin
      r_id_valid <= 1'b1;
      r_id_instr <= imem_rdata;
      r_id_pc    <= r_fetch_pc;
      r_id_pc4   <= r_fetch_pc + 32'd4;
    end else if (w_sk_xfer) begin
      r_id_valid <= 1'b1;
      r_id_instr <= r_sk_instr;
      r_id_pc    <= r_sk_pc;
      r_id_pc4   <= r_sk_pc + 32'd4;
    end else if (!stall_id) begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
    end
  end

  assign id_valid = r_id_valid;
  assign id_instr = r_id_instr;
  assign id_pc    = r_id_pc;
  assign id_pc4   = r_id_pc4;

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage: the reference is the program-order
// address stream (pc+4 per instruction, restarting at each redirect target).
module tb_if_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        stall_id = 1'b0;
  logic        bxx_flush = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        if_jalr_en = 1'b0;
  logic [31:0] jalr_target = 32'd0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall_id(stall_id), .bxx_flush(bxx_flush), .branch_target(branch_target),
    .if_jalr_en(if_jalr_en), .jalr_target(jalr_target),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  int          mem_lat = 0;
  int          lat_min = 0;
  int          lat_max = 0;
  int          rdy_pct = 100;

  logic        s_acc, s_req, s_idv;
  logic [31:0] s_acc_addr, s_addr;
  int          consumed = 0;
  int          gap = 0;
  int          max_gap = 0;
  logic        track_gap = 1'b0;
  logic [31:0] mon_e;

  logic [31:0] addrs[$];
  int          acck[$];
  logic        ok;
  logic [31:0] exp_a;
  int          cons0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not seen within cycle budget", name);
  endtask

  task automatic mem_drive();
    imem_ready = ($urandom_range(99) < rdy_pct);
    if (mem_busy && mem_lat == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(mem_addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (mem_busy) mem_lat--;
    end
  endtask

  // Finish the current cycle, then apply the given ID/redirect inputs for the next one.
  task automatic cycle(input logic st, input logic bx, input logic [31:0] bt,
                       input logic jl, input logic [31:0] jt);
    logic gave, redir;
    logic [31:0] tgt;
    @(negedge clk);
    s_acc      = imem_req & imem_ready;
    s_acc_addr = imem_addr;
    s_req      = imem_req;
    s_addr     = imem_addr;
    s_idv      = id_valid;
    gave       = imem_rvalid;
    if (imem_req) chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
    redir = bxx_flush | (if_jalr_en & ~stall_id);
    tgt   = bxx_flush ? {branch_target[31:2], 2'b00} : {jalr_target[31:2], 2'b00};
    @(posedge clk);
    #1;
    if (gave) mem_busy = 1'b0;
    if (s_acc) begin
      mem_busy = 1'b1;
      mem_addr = s_acc_addr;
      mem_lat  = $urandom_range(lat_max, lat_min);
    end
    if (redir) begin
      exp_q.delete();
      exp_q.push_back(tgt);
    end
    mem_drive();
    stall_id = st; bxx_flush = bx; branch_target = bt; if_jalr_en = jl; jalr_target = jt;
  endtask

  task automatic do_reset(input logic keep_late);
    #2;
    rst_n = 1'b0;
    stall_id = 1'b0; bxx_flush = 1'b0; if_jalr_en = 1'b0;
    imem_rvalid = 1'b0; imem_ready = 1'b0;
    #1;
    chk("rst_req",    {31'd0, imem_req}, 32'd0);
    chk("rst_addr",   imem_addr, RST_PC);
    chk("rst_valid",  {31'd0, id_valid}, 32'd0);
    chk("rst_instr",  id_instr, NOP);
    chk("rst_pc",     id_pc, 32'd0);
    chk("rst_pc4",    id_pc4, 32'd4);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(RST_PC);
    mem_busy = keep_late;
    mem_lat  = 0;
    mem_drive();
  endtask

  task automatic wait_acc(input string name, output logic found);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      found = s_acc;
    end
    if (!found) fail_now(name);
  endtask

  // Scoreboard monitor: every instruction ID takes must be the next in program order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (id_valid && !stall_id) begin
        consumed++;
        gap = 0;
        mon_e = exp_q.pop_front();
        chk("id_pc", id_pc, mon_e);
        chk("id_instr", id_instr, memf(mon_e));
        chk("id_pc4", id_pc4, mon_e + 32'd4);
        if (exp_q.size() == 0) exp_q.push_back(mon_e + 32'd4);
      end else begin
        if (!id_valid) chk("bubble_nop", id_instr, NOP);
        if (track_gap) begin
          gap++;
          if (gap > max_gap) max_gap = gap;
        end
      end
    end
  end

  initial begin
    exp_q.push_back(RST_PC);
    do_reset(1'b0);

    // zero-wait streaming from reset
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      if (s_acc) begin
        addrs.push_back(s_acc_addr);
        acck.push_back(k);
      end
      if (k >= 2) chk("first_valid", {31'd0, s_idv}, (k == 2) ? 32'd0 : 32'd1);
    end
    if (addrs.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("seq_addr", addrs[i], RST_PC + 32'd4 * i);
        chk("seq_cycle", acck[i], i + 1);
      end
    end else fail_now("seq_addr");

    // three-cycle ID stall absorbed by the skid buffer
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("stall_noreq1", {31'd0, s_req}, 32'd0);
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("stall_noreq2", {31'd0, s_req}, 32'd0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("stall_noreq3", {31'd0, s_req}, 32'd0);
    repeat (6) cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

    // branch flush with a late response outstanding to 0x10C
    lat_min = 3; lat_max = 3;
    do_reset(1'b0);
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      ok = s_acc && (s_acc_addr == 32'h0000_010C);
    end
    if (!ok) fail_now("find_10c");
    cycle(1'b0, 1'b1, 32'h0000_0203, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    wait_acc("flush_req", ok);
    if (ok) chk("flush_target", s_acc_addr, 32'h0000_0200);

    // simultaneous branch flush and JALR: branch wins
    cycle(1'b0, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_0800);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    wait_acc("prio_req", ok);
    if (ok) chk("prio_target", s_acc_addr, 32'h0000_0400);

    // JALR ignored under stall, honoured without
    wait_acc("jalr_pre", ok);
    exp_a = s_acc_addr + 32'd4;
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 32'h0000_0900);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0900);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("jalr_stall_ignored", s_addr, exp_a);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("jalr_redirect_pc", s_addr, 32'h0000_0900);
    wait_acc("jalr_req", ok);
    if (ok) chk("jalr_target", s_acc_addr, 32'h0000_0900);

    // reset while a fetch is pending; its late response must be ignored
    wait_acc("rst_pre", ok);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    lat_min = 0; lat_max = 0;
    do_reset(1'b1);
    for (int k = 0; k < 14; k++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      if (k == 1 || k == 2) chk("late_resp_ignored", {31'd0, s_idv}, 32'd0);
    end

    // randomized traffic
    lat_min = 0; lat_max = 3; rdy_pct = 70;
    cons0 = consumed;
    max_gap = 0; gap = 0; track_gap = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(99) < 25, $urandom_range(99) < 6, $urandom,
            $urandom_range(99) < 6, $urandom);
    end
    track_gap = 1'b0;
    rdy_pct = 100;
    repeat (20) cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("progress", {31'd0, (consumed - cons0) > 300}, 32'd1);
    chk("max_gap", {31'd0, max_gap < 100}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
